// File: rtl/nc_mem_responder.sv
// nc_mem_responder
//   Memory-side responder for the cache / NC-bypass request interface. Holds a
//   line-wide RAM. Writes merge per port word and per byte and produce no
//   response. Reads return the full line with the request tag unchanged, in
//   request-accept order, after LATENCY cycles.
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   mem_req_*         request channel (valid/ready handshake)
//                     rw=1 write, rw=0 read; pmask/byteen/wsel/data per port
//   mem_rsp_*         read response channel (valid/ready handshake)
module nc_mem_responder #(
  parameter int NUM_PORTS      = 1,
  parameter int CORE_DATA_SIZE = 4,
  parameter int MEM_DATA_SIZE  = 16,
  parameter int MEM_ADDR_WIDTH = 6,
  parameter int MEM_TAG_WIDTH  = 8,
  parameter int LATENCY        = 2,
  parameter int RSP_QUEUE_SIZE = 4,
  localparam int WORDS           = MEM_DATA_SIZE / CORE_DATA_SIZE,
  localparam int MEM_SELECT_BITS = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      mem_req_valid,
  input  logic                                      mem_req_rw,
  input  logic [MEM_ADDR_WIDTH-1:0]                 mem_req_addr,
  input  logic [NUM_PORTS-1:0]                      mem_req_pmask,
  input  logic [NUM_PORTS*CORE_DATA_SIZE-1:0]       mem_req_byteen,
  input  logic [NUM_PORTS*MEM_SELECT_BITS-1:0]      mem_req_wsel,
  input  logic [NUM_PORTS*CORE_DATA_SIZE*8-1:0]     mem_req_data,
  input  logic [MEM_TAG_WIDTH-1:0]                  mem_req_tag,
  output logic                                      mem_req_ready,
  output logic                                      mem_rsp_valid,
  output logic [MEM_DATA_SIZE*8-1:0]                mem_rsp_data,
  output logic [MEM_TAG_WIDTH-1:0]                  mem_rsp_tag,
  input  logic                                      mem_rsp_ready
);

  localparam int LINE_W = MEM_DATA_SIZE * 8;
  localparam int DEPTH  = 2 ** MEM_ADDR_WIDTH;
  localparam int CNT_W  = $clog2(RSP_QUEUE_SIZE + 1);
  localparam int PTR_W  = (RSP_QUEUE_SIZE > 1) ? $clog2(RSP_QUEUE_SIZE) : 1;

  typedef struct packed {
    logic [LINE_W-1:0]        data;
    logic [MEM_TAG_WIDTH-1:0] tag;
  } rsp_t;

  logic              req_fire, rd_acc, wr_acc, rsp_fire;
  logic [CNT_W-1:0]  inflight_q, inflight_d;

  assign mem_req_ready = (inflight_q < CNT_W'(RSP_QUEUE_SIZE));
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rd_acc        = req_fire && !mem_req_rw;
  assign wr_acc        = req_fire && mem_req_rw;
  assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;

  // Read credits: counted from accept until the response leaves the queue,
  // so the queue can never be pushed while full.
  always_comb begin
    inflight_d = inflight_q;
    if (rd_acc && !rsp_fire)      inflight_d = inflight_q + CNT_W'(1);
    else if (!rd_acc && rsp_fire) inflight_d = inflight_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) inflight_q <= '0;
    else       inflight_q <= inflight_d;
  end

  // ---------------------------------------------------------------- RAM
  logic [LINE_W-1:0] ram_q [DEPTH];
  logic [LINE_W-1:0] wr_line;

  // Merge ports in ascending order so a higher port wins on a shared byte.
  always_comb begin
    int unsigned w;
    w       = 0;
    wr_line = ram_q[mem_req_addr];
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (mem_req_pmask[p]) begin
        w = (WORDS > 1) ? 32'(mem_req_wsel[p*MEM_SELECT_BITS +: MEM_SELECT_BITS]) : 0;
        if (w < WORDS) begin
          for (int unsigned b = 0; b < CORE_DATA_SIZE; b++) begin
            if (mem_req_byteen[p*CORE_DATA_SIZE + b])
              wr_line[(w*CORE_DATA_SIZE + b)*8 +: 8] = mem_req_data[(p*CORE_DATA_SIZE + b)*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) ram_q[mem_req_addr] <= wr_line;
  end

  // ------------------------------------------------------ read pipeline
  // The RAM is read in the accept cycle; LATENCY-1 register stages follow
  // and the queue write supplies the last cycle of latency.
  rsp_t rd_ent, push_ent;
  logic push_vld;

  always_comb begin
    rd_ent      = '0;
    rd_ent.data = ram_q[mem_req_addr];
    rd_ent.tag  = mem_req_tag;
  end

  if (LATENCY == 1) begin : g_lat1
    assign push_vld = rd_acc;
    assign push_ent = rd_ent;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld_q;
    rsp_t               ent_q [LATENCY-1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= rd_acc;
        for (int unsigned i = 1; i < LATENCY - 1; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      ent_q[0] <= rd_ent;
      for (int unsigned i = 1; i < LATENCY - 1; i++) ent_q[i] <= ent_q[i-1];
    end

    assign push_vld = vld_q[LATENCY-2];
    assign push_ent = ent_q[LATENCY-2];
  end

  // ----------------------------------------------------- response queue
  rsp_t             q_q [RSP_QUEUE_SIZE];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] q_cnt_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_QUEUE_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      q_cnt_q  <= '0;
      for (int unsigned i = 0; i < RSP_QUEUE_SIZE; i++) q_q[i] <= '0;
    end else begin
      if (push_vld) begin
        q_q[wr_ptr_q] <= push_ent;
        wr_ptr_q      <= ptr_inc(wr_ptr_q);
      end
      if (rsp_fire) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_vld && !rsp_fire)      q_cnt_q <= q_cnt_q + CNT_W'(1);
      else if (!push_vld && rsp_fire) q_cnt_q <= q_cnt_q - CNT_W'(1);
    end
  end

  assign mem_rsp_valid = (q_cnt_q != '0);
  assign mem_rsp_data  = q_q[rd_ptr_q].data;
  assign mem_rsp_tag   = q_q[rd_ptr_q].tag;

endmodule
